// File: rtl/trace_dist_stream_pkg.sv
// Shared types for the trace-distance stream: element width default, re/im indices,
// FSM encodings and the accumulator/result width derivation used by every consumer.
package trace_dist_stream_pkg;

   localparam int NUMBER_BITS_DEF = 16;
   localparam int REAL = 0;
   localparam int IMAG = 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_SQ    = 3'd3;
   localparam logic [2:0] ST_OUT   = 3'd4;

   // One conj-product is 2*NB+1 bits; summing DIM*DIM of them adds 2*log2(DIM) bits.
   function automatic int acc_width(input int number_bits, input int dim);
      return 2 * number_bits + 1 + 2 * $clog2(dim);
   endfunction

   function automatic int dist_width(input int number_bits, input int dim);
      return 2 * acc_width(number_bits, dim);
   endfunction

endpackage

// File: rtl/trace_dist_stream_cplx_conj_mul.sv
// Combinational conj(a)*b at full precision; each output part is 2*NUMBER_BITS+1 bits.
module cplx_conj_mul
   import trace_dist_stream_pkg::*;
#(
   parameter int NUMBER_BITS = NUMBER_BITS_DEF,
   localparam int PW = 2 * NUMBER_BITS + 1
) (
   input  logic signed [NUMBER_BITS-1:0] a_re,
   input  logic signed [NUMBER_BITS-1:0] a_im,
   input  logic signed [NUMBER_BITS-1:0] b_re,
   input  logic signed [NUMBER_BITS-1:0] b_im,
   output logic signed [PW-1:0]          p_re,
   output logic signed [PW-1:0]          p_im
);

   logic signed [PW-1:0] ar;
   logic signed [PW-1:0] ai;
   logic signed [PW-1:0] br;
   logic signed [PW-1:0] bi;

   // Operands are sign-extended first so the products and sum never wrap.
   always_comb begin
      ar   = PW'(a_re);
      ai   = PW'(a_im);
      br   = PW'(b_re);
      bi   = PW'(b_im);
      p_re = ar * br + ai * bi;
      p_im = ar * bi - ai * br;
   end

endmodule

// File: rtl/trace_dist_stream.sv
// Streams A and B element addresses, accumulates trace(A^H*B), squares it into dist2,
// and keeps the smallest dist2 (with its job tag) seen since the last clear_best.
module trace_dist_stream
   import trace_dist_stream_pkg::*;
#(
   parameter int NUMBER_BITS = NUMBER_BITS_DEF,
   parameter int DIM         = 2,
   parameter int TAG_BITS    = 8,
   localparam int IDX_BITS   = $clog2(DIM),
   localparam int ACC_W      = acc_width(NUMBER_BITS, DIM),
   localparam int D_W        = dist_width(NUMBER_BITS, DIM)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [TAG_BITS-1:0]           start_tag,
   output logic                          ready,
   output logic                          addr_valid,
   output logic [IDX_BITS-1:0]           addr_row,
   output logic [IDX_BITS-1:0]           addr_col,
   input  logic signed [NUMBER_BITS-1:0] a_re,
   input  logic signed [NUMBER_BITS-1:0] a_im,
   input  logic signed [NUMBER_BITS-1:0] b_re,
   input  logic signed [NUMBER_BITS-1:0] b_im,
   output logic [D_W-1:0]                dist2,
   output logic                          dist_valid,
   output logic [TAG_BITS-1:0]           dist_tag,
   input  logic                          clear_best,
   output logic [D_W-1:0]                best_dist2,
   output logic [TAG_BITS-1:0]           best_tag,
   output logic                          best_valid
);

   localparam int N2    = DIM * DIM;
   localparam int CNT_W = 2 * IDX_BITS;
   localparam int PW    = 2 * NUMBER_BITS + 1;

   logic [2:0]              state;
   logic [2:0]              state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic                    sample_valid;
   logic [TAG_BITS-1:0]     job_tag;
   logic signed [ACC_W-1:0] acc_re;
   logic signed [ACC_W-1:0] acc_im;
   logic signed [PW-1:0]    prod_re;
   logic signed [PW-1:0]    prod_im;
   logic signed [D_W-1:0]   acc_re_ext;
   logic signed [D_W-1:0]   acc_im_ext;
   logic [D_W-1:0]          sq_re;
   logic [D_W-1:0]          sq_im;
   logic [D_W-1:0]          dist_sum;
   logic                    accept;
   logic                    last_addr;
   logic                    load_result;
   logic                    best_valid_eff;
   logic                    take_best;

   cplx_conj_mul #(
      .NUMBER_BITS(NUMBER_BITS)
   ) u_mul (
      .a_re(a_re),
      .a_im(a_im),
      .b_re(b_re),
      .b_im(b_im),
      .p_re(prod_re),
      .p_im(prod_im)
   );

   // OUT is the last busy cycle; accepting there overlaps the next job with the result load.
   assign ready       = (state == ST_IDLE) || (state == ST_OUT);
   assign accept      = start && ready;
   assign addr_valid  = (state == ST_RUN);
   assign {addr_row, addr_col} = cnt;
   assign last_addr   = (cnt == CNT_W'(N2 - 1));
   assign load_result = (state == ST_OUT);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_RUN;
         ST_RUN:   if (last_addr) state_nxt = ST_DRAIN;
         ST_DRAIN: state_nxt = ST_SQ;
         ST_SQ:    state_nxt = ST_OUT;
         ST_OUT:   state_nxt = accept ? ST_RUN : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         sample_valid <= 1'b0;
         job_tag      <= '0;
      end else begin
         state        <= state_nxt;
         sample_valid <= addr_valid;
         if (state == ST_RUN && !last_addr) cnt <= cnt + 1'b1;
         else                              cnt <= '0;
         if (accept) job_tag <= start_tag;
      end
   end

   // Read data lags its address by one cycle, so sample_valid marks the MAC cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_re <= '0;
         acc_im <= '0;
      end else if (accept) begin
         acc_re <= '0;
         acc_im <= '0;
      end else if (sample_valid) begin
         acc_re <= acc_re + ACC_W'(prod_re);
         acc_im <= acc_im + ACC_W'(prod_im);
      end
   end

   assign acc_re_ext = D_W'(acc_re);
   assign acc_im_ext = D_W'(acc_im);
   assign dist_sum   = sq_re + sq_im;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sq_re <= '0;
         sq_im <= '0;
      end else if (state == ST_SQ) begin
         sq_re <= $unsigned(acc_re_ext * acc_re_ext);
         sq_im <= $unsigned(acc_im_ext * acc_im_ext);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dist2      <= '0;
         dist_tag   <= '0;
         dist_valid <= 1'b0;
      end else begin
         dist_valid <= load_result;
         if (load_result) begin
            dist2    <= dist_sum;
            dist_tag <= job_tag;
         end
      end
   end

   // A same-edge clear is applied before the compare, so a coincident result always wins.
   assign best_valid_eff = best_valid && !clear_best;
   assign take_best      = load_result && (!best_valid_eff || (dist_sum < best_dist2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         best_dist2 <= '0;
         best_tag   <= '0;
         best_valid <= 1'b0;
      end else if (take_best) begin
         best_dist2 <= dist_sum;
         best_tag   <= job_tag;
         best_valid <= 1'b1;
      end else if (clear_best) begin
         best_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_trace_dist_stream.sv
// Directed bench for trace_dist_stream: DIM=2 and DIM=4 instances, each fed by a
// one-cycle-latency matrix store model.
module tb_trace_dist_stream;

   logic               clk;
   logic               reset;

   logic               start;
   logic [7:0]         start_tag;
   logic               ready;
   logic               addr_valid;
   logic [0:0]         addr_row;
   logic [0:0]         addr_col;
   logic signed [15:0] a_re, a_im, b_re, b_im;
   logic [69:0]        dist2;
   logic               dist_valid;
   logic [7:0]         dist_tag;
   logic               clear_best;
   logic [69:0]        best_dist2;
   logic [7:0]         best_tag;
   logic               best_valid;

   logic               start4;
   logic [7:0]         start_tag4;
   logic               ready4;
   logic               addr_valid4;
   logic [1:0]         addr_row4;
   logic [1:0]         addr_col4;
   logic signed [15:0] a4_re, a4_im, b4_re, b4_im;
   logic [73:0]        dist2_4;
   logic               dist_valid4;
   logic [7:0]         dist_tag4;
   logic               clear_best4;
   logic [73:0]        best_dist2_4;
   logic [7:0]         best_tag4;
   logic               best_valid4;

   logic signed [15:0] ma_re [4];
   logic signed [15:0] ma_im [4];
   logic signed [15:0] mb_re [4];
   logic signed [15:0] mb_im [4];
   logic signed [15:0] m4a_re [16];
   logic signed [15:0] m4b_re [16];

   int vectors;
   int miscompares;

   trace_dist_stream #(.NUMBER_BITS(16), .DIM(2), .TAG_BITS(8)) u_dut (
      .clk(clk), .reset(reset), .start(start), .start_tag(start_tag), .ready(ready),
      .addr_valid(addr_valid), .addr_row(addr_row), .addr_col(addr_col),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .dist2(dist2), .dist_valid(dist_valid), .dist_tag(dist_tag), .clear_best(clear_best),
      .best_dist2(best_dist2), .best_tag(best_tag), .best_valid(best_valid)
   );

   trace_dist_stream #(.NUMBER_BITS(16), .DIM(4), .TAG_BITS(8)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4), .start_tag(start_tag4), .ready(ready4),
      .addr_valid(addr_valid4), .addr_row(addr_row4), .addr_col(addr_col4),
      .a_re(a4_re), .a_im(a4_im), .b_re(b4_re), .b_im(b4_im),
      .dist2(dist2_4), .dist_valid(dist_valid4), .dist_tag(dist_tag4), .clear_best(clear_best4),
      .best_dist2(best_dist2_4), .best_tag(best_tag4), .best_valid(best_valid4)
   );

   always #5 clk = ~clk;

   // Store model: data appears the cycle after its address; junk otherwise.
   always @(posedge clk) begin
      if (addr_valid) begin
         a_re <= ma_re[{addr_row, addr_col}];
         a_im <= ma_im[{addr_row, addr_col}];
         b_re <= mb_re[{addr_row, addr_col}];
         b_im <= mb_im[{addr_row, addr_col}];
      end else begin
         a_re <= 16'sh5A5A;
         a_im <= 16'sh1234;
         b_re <= 16'sh6B6B;
         b_im <= -16'sh0777;
      end
      if (addr_valid4) begin
         a4_re <= m4a_re[{addr_row4, addr_col4}];
         b4_re <= m4b_re[{addr_row4, addr_col4}];
         a4_im <= 16'sd0;
         b4_im <= 16'sd0;
      end else begin
         a4_re <= 16'sh3C3C;
         b4_re <= 16'sh4D4D;
         a4_im <= 16'sh0101;
         b4_im <= 16'sh0202;
      end
   end

   task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mats();
      for (int i = 0; i < 4; i++) begin
         ma_re[i] = '0; ma_im[i] = '0; mb_re[i] = '0; mb_im[i] = '0;
      end
      for (int i = 0; i < 16; i++) begin
         m4a_re[i] = '0; m4b_re[i] = '0;
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready) check_output("ready_timeout", 128'(ready), 128'(1));
   endtask

   // One DIM=2 job: checks address stream, busy flag, and the result exactly 7 edges later.
   task automatic apply_stimulus(input logic [7:0] tag, input logic [127:0] exp, input logic clr);
      wait_ready();
      @(negedge clk);
      start = 1'b1;
      start_tag = tag;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_output("addr_valid", 128'(addr_valid), 128'(1));
         check_output("addr", 128'({addr_row, addr_col}), 128'(k));
         check_output("busy", 128'(ready), 128'(0));
         @(posedge clk); #1;
      end
      check_output("addr_valid_end", 128'(addr_valid), 128'(0));
      @(posedge clk); #1;
      check_output("dv_early5", 128'(dist_valid), 128'(0));
      @(posedge clk); #1;
      check_output("dv_early6", 128'(dist_valid), 128'(0));
      check_output("ready_out", 128'(ready), 128'(1));
      @(negedge clk);
      clear_best = clr;
      @(posedge clk); #1;
      clear_best = 1'b0;
      check_output("dist_valid", 128'(dist_valid), 128'(1));
      check_output("dist2", 128'(dist2), exp);
      check_output("dist_tag", 128'(dist_tag), 128'(tag));
      @(posedge clk); #1;
      check_output("dv_pulse", 128'(dist_valid), 128'(0));
   endtask

   task automatic check_best(input logic [127:0] exp_d, input logic [7:0] exp_t, input logic exp_v);
      check_output("best_dist2", 128'(best_dist2), exp_d);
      check_output("best_tag", 128'(best_tag), 128'(exp_t));
      check_output("best_valid", 128'(best_valid), 128'(exp_v));
   endtask

   task automatic set_diag(input logic signed [15:0] a0, input logic signed [15:0] a3,
                           input logic signed [15:0] b0, input logic signed [15:0] b3);
      clear_mats();
      ma_re[0] = a0; ma_re[3] = a3; mb_re[0] = b0; mb_re[3] = b3;
   endtask

   initial begin
      int pulses;
      int ph;
      int n;
      clk = 0; reset = 0; start = 0; start_tag = '0; clear_best = 0;
      start4 = 0; start_tag4 = '0; clear_best4 = 0;
      vectors = 0; miscompares = 0;
      clear_mats();

      #12;
      check_output("rst_ready", 128'(ready), 128'(1));
      check_output("rst_addr_valid", 128'(addr_valid), 128'(0));
      check_output("rst_addr", 128'({addr_row, addr_col}), 128'(0));
      check_output("rst_dist_valid", 128'(dist_valid), 128'(0));
      check_output("rst_dist2", 128'(dist2), 128'(0));
      check_output("rst_dist_tag", 128'(dist_tag), 128'(0));
      check_best(128'(0), 8'h00, 1'b0);
      @(negedge clk);
      reset = 1;

      set_diag(16'sd1, 16'sd1, 16'sd1, 16'sd1);
      apply_stimulus(8'h11, 128'(4), 1'b0);
      check_best(128'(4), 8'h11, 1'b1);

      set_diag(16'sd1, 16'sd1, 16'sd1, -16'sd1);
      apply_stimulus(8'h12, 128'(0), 1'b0);
      check_best(128'(0), 8'h12, 1'b1);

      set_diag(16'sd1, 16'sd1, 16'sd0, 16'sd0);
      mb_im[0] = 16'sd1; mb_im[3] = 16'sd1;
      apply_stimulus(8'h13, 128'(4), 1'b0);

      for (int i = 0; i < 4; i++) begin
         ma_re[i] = 16'h8000; ma_im[i] = 16'h8000; mb_re[i] = 16'h8000; mb_im[i] = 16'h8000;
      end
      apply_stimulus(8'h14, 128'(1) << 66, 1'b0);
      check_best(128'(0), 8'h12, 1'b1);

      @(negedge clk); clear_best = 1'b1;
      @(posedge clk); #1; clear_best = 1'b0;
      check_best(128'(0), 8'h12, 1'b0);
      @(posedge clk); #1;
      check_output("best_stays_invalid", 128'(best_valid), 128'(0));

      set_diag(16'sd1, 16'sd1, 16'sd3, 16'sd0);
      apply_stimulus(8'h01, 128'(9), 1'b0);
      check_best(128'(9), 8'h01, 1'b1);
      set_diag(16'sd1, 16'sd1, 16'sd2, 16'sd0);
      apply_stimulus(8'h02, 128'(4), 1'b0);
      check_best(128'(4), 8'h02, 1'b1);
      set_diag(16'sd1, 16'sd1, 16'sd0, 16'sd2);
      apply_stimulus(8'h03, 128'(4), 1'b0);
      check_best(128'(4), 8'h02, 1'b1);
      set_diag(16'sd1, 16'sd1, 16'sd4, 16'sd0);
      apply_stimulus(8'h04, 128'(16), 1'b1);
      check_best(128'(16), 8'h04, 1'b1);
      @(negedge clk); clear_best = 1'b1;
      @(posedge clk); #1; clear_best = 1'b0;
      check_best(128'(16), 8'h04, 1'b0);

      set_diag(16'sd1, 16'sd1, 16'sd1, 16'sd1);
      wait_ready();
      @(negedge clk);
      start = 1'b1;
      start_tag = 8'h21;
      for (int c = 0; c < 22; c++) begin
         @(posedge clk); #1;
         ph = c % 7;
         check_output("held_addr_valid", 128'(addr_valid), 128'(ph < 4 && c < 21));
         if (ph < 4 && c < 21) check_output("held_addr", 128'({addr_row, addr_col}), 128'(ph));
         check_output("held_ready", 128'(ready), 128'(ph == 6 || c == 21));
         check_output("held_dist_valid", 128'(dist_valid), 128'(c >= 7 && ph == 0));
         if (c >= 7 && ph == 0) begin
            check_output("held_dist2", 128'(dist2), 128'(4));
            check_output("held_tag", 128'(dist_tag), 128'(8'h21));
         end
         if (c == 20) start = 1'b0;
      end

      wait_ready();
      @(negedge clk);
      start = 1'b1;
      start_tag = 8'h31;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_output("pre_reset_addr", 128'({addr_row, addr_col}), 128'(2));
      #2 reset = 1'b0;
      #1;
      check_output("arst_addr_valid", 128'(addr_valid), 128'(0));
      check_output("arst_addr", 128'({addr_row, addr_col}), 128'(0));
      check_output("arst_ready", 128'(ready), 128'(1));
      check_output("arst_dist2", 128'(dist2), 128'(0));
      check_output("arst_dist_tag", 128'(dist_tag), 128'(0));
      check_best(128'(0), 8'h00, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (dist_valid) pulses++;
      end
      check_output("no_pulse_after_abort", 128'(pulses), 128'(0));
      apply_stimulus(8'h32, 128'(4), 1'b0);
      check_best(128'(4), 8'h32, 1'b1);

      m4a_re[0] = 16'sd1; m4a_re[5] = 16'sd1; m4a_re[10] = 16'sd1; m4a_re[15] = 16'sd1;
      m4b_re[0] = 16'sd1; m4b_re[5] = 16'sd1; m4b_re[10] = 16'sd1; m4b_re[15] = 16'sd1;
      n = 0;
      while (!ready4 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_output("d4_ready", 128'(ready4), 128'(1));
      @(negedge clk);
      start4 = 1'b1;
      start_tag4 = 8'h44;
      @(posedge clk); #1;
      start4 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check_output("d4_addr_valid", 128'(addr_valid4), 128'(1));
         check_output("d4_addr", 128'({addr_row4, addr_col4}), 128'(k));
         @(posedge clk); #1;
      end
      check_output("d4_addr_valid_end", 128'(addr_valid4), 128'(0));
      for (int e = 16; e <= 19; e++) begin
         check_output("d4_dist_valid", 128'(dist_valid4), 128'(e == 19));
         if (e != 19) begin
            @(posedge clk); #1;
         end
      end
      check_output("d4_dist2", 128'(dist2_4), 128'(16));
      check_output("d4_tag", 128'(dist_tag4), 128'(8'h44));
      check_output("d4_best_dist2", 128'(best_dist2_4), 128'(16));
      check_output("d4_best_tag", 128'(best_tag4), 128'(8'h44));
      check_output("d4_best_valid", 128'(best_valid4), 128'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
